// File: rtl/seg7_pkg.sv
// Glyph table and shared types for the multiplexed 7-segment display path.
// The display driver and the scan decoder both import this package.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns (g..a). Entry n encodes hex digit n.
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef logic [1:0] seg_state_t;
    localparam seg_state_t IDLE     = 2'd0;
    localparam seg_state_t SETTLE   = 2'd1;
    localparam seg_state_t CAPTURED = 2'd2;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_dec_t;

endpackage

// File: rtl/seg7_scan_if.sv
// Multiplexed display bus: active-low cathodes (DP + g..a) and active-low anodes.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [7:0]            ca;
    logic [NUM_DIGITS-1:0] an;

    modport master (output ca, an);
    modport slave  (input  ca, an);
endinterface

// File: rtl/seg7_inverse.sv
// Combinational inverse of the glyph table: segment pattern -> nibble.
// A blank pattern is reported separately and is not a legal glyph.
module seg7_inverse
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output seg_dec_t   dec
);

    always_comb begin
        dec        = '0;
        dec.blank  = (seg == SEG_BLANK);
        for (int g = 0; g < 16; g++) begin
            if (seg == SEG_GLYPH[g]) begin
                dec.legal  = 1'b1;
                dec.nibble = 4'(g);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the scanned 7-segment bus: settles each scan slot, decodes the
// glyph into a per-digit register file and strobes once every digit was captured.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seg7_scan_if.slave              bus,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   seen,
    output logic                    frame_stb,
    output logic                    frame_valid,
    output logic                    err_seg,
    output logic                    err_an
);

    localparam int                    CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = NUM_DIGITS'(1);

    logic [7:0]            ca_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    seg_state_t            state, state_nxt;

    logic                  changed, idle_in, eval;
    logic [NUM_DIGITS-1:0] low, cap_bit;
    logic                  multi_low, one_low, cap_ok, seen_all;
    seg_dec_t              dec;

    // The counter tracks edges since the registered sample last changed, so the
    // capture edge lands SETTLE_CYCLES+1 edges after a pin change.
    assign changed = ({bus.ca, bus.an} != {ca_q, an_q});
    assign idle_in = &bus.an;

    always_comb begin
        cnt_nxt = cnt;
        if (changed)
            cnt_nxt = '0;
        else if (cnt != CNT_MAX)
            cnt_nxt = cnt + CNT_ONE;
    end

    assign eval = (state == SETTLE) && !changed && (cnt_nxt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        if (changed)
            state_nxt = idle_in ? IDLE : SETTLE;
        else if (eval)
            state_nxt = CAPTURED;
    end

    seg7_inverse u_inverse (
        .seg (ca_q[6:0]),
        .dec (dec)
    );

    // Clearing the lowest set bit leaves something only when two or more anodes are low.
    assign low       = ~an_q;
    assign multi_low = |(low & (low - AN_ONE));
    assign one_low   = (low != '0) && !multi_low;
    assign cap_ok    = eval && one_low && (dec.legal || dec.blank);
    assign cap_bit   = cap_ok ? low : '0;
    assign seen_all  = &(seen | cap_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_q  <= '1;
            an_q  <= '1;
            cnt   <= '0;
            state <= IDLE;
        end else begin
            ca_q  <= bus.ca;
            an_q  <= bus.an;
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen        <= '0;
            frame_stb   <= 1'b0;
            frame_valid <= 1'b0;
            err_seg     <= 1'b0;
            err_an      <= 1'b0;
        end else begin
            frame_stb <= cap_ok && seen_all;
            err_an    <= eval && multi_low;
            err_seg   <= eval && one_low && !dec.legal && !dec.blank;
            if (cap_ok) begin
                seen <= seen_all ? '0 : (seen | cap_bit);
                if (seen_all)
                    frame_valid <= 1'b1;
            end
        end
    end

    // Per-digit register file; a blank capture keeps the old nibble.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [3:0] nib_r;
        logic       dp_r, blank_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                nib_r   <= '0;
                dp_r    <= 1'b0;
                blank_r <= 1'b0;
            end else if (cap_bit[g]) begin
                dp_r    <= ~ca_q[7];
                blank_r <= dec.blank;
                if (dec.legal)
                    nib_r <= dec.nibble;
            end
        end

        assign digits[4*g +: 4] = nib_r;
        assign dp[g]            = dp_r;
        assign blank[g]         = blank_r;
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed vector table, corner sequences and
// randomized scan slots checked against a slot-level reference model.
module tb_seg7_scan_decoder;

    localparam int ND = 8;
    localparam int SC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_if #(.NUM_DIGITS(ND)) bus();

    logic [31:0] digits;
    logic [7:0]  dp, blank, seen;
    logic        frame_stb, frame_valid, err_seg, err_an;

    seg7_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .seen        (seen),
        .frame_stb   (frame_stb),
        .frame_valid (frame_valid),
        .err_seg     (err_seg),
        .err_an      (err_an)
    );

    int total = 0;
    int bad   = 0;
    int n_stb, n_eseg, n_ean;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [7:0]  an;
        logic [7:0]  ca;
        logic [31:0] dig;
        logic [7:0]  dpv;
        logic [7:0]  blk;
        logic [7:0]  sn;
        logic        vld;
        int          stb;
        int          eseg;
        int          ean;
    } vec_t;
    vec_t tv [14];

    // slot-level reference model state
    logic [3:0]  m_dig [ND];
    logic [7:0]  m_dp, m_blank, m_seen;
    logic        m_valid;
    int          e_stb, e_eseg, e_ean;
    logic [15:0] prev_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_stb) n_stb++;
            if (err_seg)   n_eseg++;
            if (err_an)    n_ean++;
        end
    endtask

    task automatic clr();
        n_stb = 0; n_eseg = 0; n_ean = 0;
    endtask

    task automatic drive(input logic [7:0] an, input logic [7:0] ca);
        bus.an = an;
        bus.ca = ca;
    endtask

    // -1: illegal pattern, -2: blank, otherwise the hex value
    function automatic int glyph_of(input logic [6:0] s);
        if (s == 7'h7F) return -2;
        for (int k = 0; k < 16; k++)
            if (glyph[k] == s) return k;
        return -1;
    endfunction

    function automatic logic [31:0] m_digits();
        logic [31:0] v = '0;
        for (int k = 0; k < ND; k++) v[4*k +: 4] = m_dig[k];
        return v;
    endfunction

    // A slot is evaluated only if it is a fresh value on a driven anode held long enough.
    task automatic model_slot(input logic [7:0] an, input logic [7:0] ca, input int len);
        int idx, g;
        e_stb = 0; e_eseg = 0; e_ean = 0;
        if ({an, ca} != prev_in && an != 8'hFF && len >= SC + 1) begin
            if ($countones(~an) > 1) begin
                e_ean = 1;
            end else begin
                idx = 0;
                for (int k = 0; k < ND; k++) if (!an[k]) idx = k;
                g = glyph_of(ca[6:0]);
                if (g == -1) begin
                    e_eseg = 1;
                end else begin
                    if (g >= 0) begin
                        m_dig[idx]   = 4'(g);
                        m_blank[idx] = 1'b0;
                    end else begin
                        m_blank[idx] = 1'b1;
                    end
                    m_dp[idx]   = ~ca[7];
                    m_seen[idx] = 1'b1;
                    if (m_seen == 8'hFF) begin
                        m_seen  = '0;
                        m_valid = 1'b1;
                        e_stb   = 1;
                    end
                end
            end
        end
        prev_in = {an, ca};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int len, r, i, j;
        logic [7:0] an, ca;
        logic dpb;

        tv[0]  = '{8'hFE, 8'hF9, 32'h00000001, 8'h00, 8'h00, 8'h01, 1'b0, 0, 0, 0};
        tv[1]  = '{8'hFD, 8'hC0, 32'h00000001, 8'h00, 8'h00, 8'h03, 1'b0, 0, 0, 0};
        tv[2]  = '{8'hFB, 8'hA4, 32'h00000201, 8'h00, 8'h00, 8'h07, 1'b0, 0, 0, 0};
        tv[3]  = '{8'hF7, 8'h80, 32'h00008201, 8'h00, 8'h00, 8'h0F, 1'b0, 0, 0, 0};
        tv[4]  = '{8'hEF, 8'h8E, 32'h000F8201, 8'h00, 8'h00, 8'h1F, 1'b0, 0, 0, 0};
        tv[5]  = '{8'hDF, 8'hC0, 32'h000F8201, 8'h00, 8'h00, 8'h3F, 1'b0, 0, 0, 0};
        tv[6]  = '{8'hBF, 8'hC0, 32'h000F8201, 8'h00, 8'h00, 8'h7F, 1'b0, 0, 0, 0};
        tv[7]  = '{8'h7F, 8'hC0, 32'h000F8201, 8'h00, 8'h00, 8'h00, 1'b1, 1, 0, 0};
        tv[8]  = '{8'hFC, 8'hC0, 32'h000F8201, 8'h00, 8'h00, 8'h00, 1'b1, 0, 0, 1};
        tv[9]  = '{8'hFB, 8'hFF, 32'h000F8201, 8'h00, 8'h04, 8'h04, 1'b1, 0, 0, 0};
        tv[10] = '{8'hFB, 8'h7F, 32'h000F8201, 8'h04, 8'h04, 8'h04, 1'b1, 0, 0, 0};
        tv[11] = '{8'hF7, 8'hAA, 32'h000F8201, 8'h04, 8'h04, 8'h04, 1'b1, 0, 1, 0};
        tv[12] = '{8'hF7, 8'hA4, 32'h000F2201, 8'h04, 8'h04, 8'h0C, 1'b1, 0, 0, 0};
        tv[13] = '{8'hFF, 8'hFF, 32'h000F2201, 8'h04, 8'h04, 8'h0C, 1'b1, 0, 0, 0};

        // reset, then an idle bus must stay silent
        drive(8'hFF, 8'hFF);
        clr();
        tick(3);
        chk("reset_outputs", 64'({digits, dp, blank, seen, frame_stb, frame_valid, err_seg, err_an}), 64'd0);
        rst_n = 1'b1;
        tick(100);
        chk("idle_outputs", 64'({digits, dp, blank, seen, frame_stb, frame_valid, err_seg, err_an}), 64'd0);
        chk("idle_pulses", 64'(n_stb + n_eseg + n_ean), 64'd0);

        // first capture latency
        drive(8'hFE, 8'hF9);
        first = -1;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (first < 0 && seen[0]) first = c;
        end
        chk("capture_latency", 64'(first), 64'(SC + 1));
        chk("lat_digits", 64'(digits), 64'h1);
        chk("lat_dp", 64'(dp), 64'h0);

        // directed vector table: frame scan, multi-anode, blank, blank+DP, illegal glyph
        for (int t = 0; t < 14; t++) begin
            drive(tv[t].an, tv[t].ca);
            clr();
            tick(40);
            chk($sformatf("tv%0d_digits", t), 64'(digits), 64'(tv[t].dig));
            chk($sformatf("tv%0d_dp", t), 64'(dp), 64'(tv[t].dpv));
            chk($sformatf("tv%0d_blank", t), 64'(blank), 64'(tv[t].blk));
            chk($sformatf("tv%0d_seen", t), 64'(seen), 64'(tv[t].sn));
            chk($sformatf("tv%0d_valid", t), 64'(frame_valid), 64'(tv[t].vld));
            chk($sformatf("tv%0d_pulses", t), 64'({n_stb[7:0], n_eseg[7:0], n_ean[7:0]}),
                64'({tv[t].stb[7:0], tv[t].eseg[7:0], tv[t].ean[7:0]}));
        end

        // anode glitch shorter than the settle window
        clr();
        drive(8'hFB, 8'hC0);
        tick(5);
        drive(8'hFF, 8'hFF);
        tick(30);
        chk("glitch_digits", 64'(digits), 64'h000F2201);
        chk("glitch_seen", 64'(seen), 64'h0C);
        chk("glitch_pulses", 64'(n_stb + n_eseg + n_ean), 64'd0);

        // reset in the middle of a settle, then a full settle is needed again
        drive(8'hFE, 8'hF9);
        tick(11);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 64'({digits, dp, blank, seen, frame_stb, frame_valid, err_seg, err_an}), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(SC);
        chk("midreset_early", 64'(seen), 64'h0);
        tick(1);
        chk("midreset_capture_seen", 64'(seen), 64'h01);
        chk("midreset_capture_dig", 64'(digits), 64'h1);

        // randomized slots vs reference model
        for (int k = 0; k < ND; k++) m_dig[k] = '0;
        m_dig[0] = 4'h1;
        m_dp = '0; m_blank = '0; m_seen = 8'h01; m_valid = 1'b0;
        prev_in = {8'hFE, 8'hF9};
        for (int s = 0; s < 300; s++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 10) begin
                    an = 8'hFF;
                end else if (r < 80) begin
                    an = ~(8'h01 << $urandom_range(0, 7));
                end else begin
                    i  = $urandom_range(0, 7);
                    j  = (i + $urandom_range(1, 7)) % 8;
                    an = ~((8'h01 << i) | (8'h01 << j));
                end
                r   = $urandom_range(0, 99);
                dpb = 1'($urandom_range(0, 1));
                if (r < 60)      ca = {dpb, glyph[$urandom_range(0, 15)]};
                else if (r < 75) ca = {dpb, 7'h7F};
                else             ca = 8'($urandom);
            end while ({an, ca} == prev_in);
            len = $urandom_range(1, 30);
            drive(an, ca);
            clr();
            tick(len);
            model_slot(an, ca, len);
            chk("rnd_digits", 64'(digits), 64'(m_digits()));
            chk("rnd_dp", 64'(dp), 64'(m_dp));
            chk("rnd_blank", 64'(blank), 64'(m_blank));
            chk("rnd_seen", 64'(seen), 64'(m_seen));
            chk("rnd_valid", 64'(frame_valid), 64'(m_valid));
            chk("rnd_pulses", 64'({n_stb[7:0], n_eseg[7:0], n_ean[7:0]}),
                64'({e_stb[7:0], e_eseg[7:0], e_ean[7:0]}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
